write_latency: RTL

//  Measures the latency of a single Avalon-MM store: on one Avalon-ST kernel call it issues one

---
 rtl/write_latency.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/write_latency.sv
// write_latency
//   Measures the latency of a single global-memory store. One kernel call
//   (Avalon-ST style valid/ready) issues exactly one burst-1 Avalon-MM write
//   and counts CLK cycles until dst_writeack. The count is the call result.
//
//   Configuration macro: WRITE_LATENCY_VERIFY_EN
//     defined     - after the ack, the same line is read back and the stored
//                   lane is compared. The result is the cycle count on a match
//                   and 0 on a mismatch.
//     not defined - no read-back. dst_read is tied 0 and the result is the
//                   cycle count.
//
//   Parameters
//     WIDTH    bits of the stored value (power of 2, 8..512)
//     TIMEOUT  cycles without writeack before the access is abandoned
//
//   Ports
//     CLK, RST                      clock, synchronous active-high reset
//     m_dst_addr, m_input_index,    call arguments: buffer base (bytes),
//     m_input_value                 element index, value to store
//     m_valid_in / m_ready_out      call handshake
//     m_valid_out / m_ready_in      result handshake
//     m_output_value                latency (0 = verify fail, FFFFFFFF = timeout)
//     dst_*                         512-bit Avalon-MM master
module write_latency #(
  parameter int          WIDTH   = 32,
  parameter logic [31:0] TIMEOUT = 32'hFFFFFFF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [63:0]      m_dst_addr,
  input  logic [31:0]      m_input_index,
  input  logic [WIDTH-1:0] m_input_value,
  output logic [31:0]      m_output_value,
  output logic             m_ready_out,
  input  logic             m_valid_in,
  output logic             m_valid_out,
  input  logic             m_ready_in,
  output logic [31:0]      dst_address,
  output logic             dst_write,
  output logic             dst_read,
  input  logic             dst_waitrequest,
  input  logic             dst_writeack,
  input  logic [511:0]     dst_readdata,
  input  logic             dst_readdatavalid,
  output logic [511:0]     dst_writedata,
  output logic [63:0]      dst_byteenable,
  output logic [4:0]       dst_burstcount
);

  localparam int LANE_BYTES = WIDTH / 8;
  localparam int LANES      = 512 / WIDTH;
  localparam int SH         = $clog2(LANE_BYTES);
  localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {IDLE, WREQ, WACK, RREQ, RDAT, DONE} state_t;

  state_t state_reg, state_next;

  logic [31:0]      address_reg;
  logic [511:0]     writedata_reg;
  logic [63:0]      byteenable_reg;
  logic [31:0]      cycle_reg;
  logic [31:0]      result_reg;

  logic             start;
  logic [31:0]      byte_addr;
  logic [LW-1:0]    lane_next;
  logic [511:0]     writedata_next;
  logic [63:0]      byteenable_next;
  logic [31:0]      cycle_inc;
  logic             timeout_hit;
  logic             in_write;

  assign start       = m_ready_out & m_valid_in;
  // Only the low 32 address bits reach the port, so the sum is taken mod 2^32.
  assign byte_addr   = m_dst_addr[31:0] + (m_input_index << SH);
  assign lane_next   = LW'(byte_addr[5:0] >> SH);
  assign cycle_inc   = (cycle_reg == 32'hFFFF_FFFF) ? cycle_reg : cycle_reg + 32'd1;
  assign timeout_hit = (cycle_reg == TIMEOUT);
  assign in_write    = (state_reg == WREQ) || (state_reg == WACK);

  // Place the value in its lane of the 512-bit line, zero elsewhere.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign writedata_next[gi*WIDTH +: WIDTH] =
      (lane_next == LW'(gi)) ? m_input_value : '0;
    assign byteenable_next[gi*LANE_BYTES +: LANE_BYTES] =
      (lane_next == LW'(gi)) ? '1 : '0;
  end

`ifdef WRITE_LATENCY_VERIFY_EN
  localparam state_t AFTER_ACK = RREQ;

  logic [LW-1:0]    lane_reg;
  logic [WIDTH-1:0] value_reg;
  logic [31:0]      rd_wait_reg;
  logic [WIDTH-1:0] rd_lanes [LANES];
  logic             rd_timeout;
  logic             rd_match;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_rd_lane
    assign rd_lanes[gi] = dst_readdata[gi*WIDTH +: WIDTH];
  end

  // Read cycles are not part of the latency, so the read phase has its own
  // timeout counter.
  assign rd_timeout = (rd_wait_reg == TIMEOUT);
  assign rd_match   = (rd_lanes[lane_reg] == value_reg);
  assign dst_read   = (state_reg == RREQ);

  logic unused_bits;
  assign unused_bits = ^{m_dst_addr[63:32]};
`else
  localparam state_t AFTER_ACK = DONE;

  assign dst_read = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{m_dst_addr[63:32], dst_readdata, dst_readdatavalid};
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. A writeack wins over a timeout in the same cycle since
  // the store did complete.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = WREQ;
      WREQ: begin
        if (dst_writeack)          state_next = AFTER_ACK;
        else if (timeout_hit)      state_next = DONE;
        else if (!dst_waitrequest) state_next = WACK;
      end
      WACK: begin
        if (dst_writeack)     state_next = AFTER_ACK;
        else if (timeout_hit) state_next = DONE;
      end
`ifdef WRITE_LATENCY_VERIFY_EN
      RREQ: begin
        if (rd_timeout)            state_next = DONE;
        else if (!dst_waitrequest) state_next = RDAT;
      end
      RDAT: begin
        if (dst_readdatavalid) state_next = DONE;
        else if (rd_timeout)   state_next = DONE;
      end
`endif
      DONE: if (m_ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: request capture, latency counter and result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      address_reg    <= '0;
      writedata_reg  <= '0;
      byteenable_reg <= '0;
      cycle_reg      <= '0;
      result_reg     <= '0;
`ifdef WRITE_LATENCY_VERIFY_EN
      lane_reg       <= '0;
      value_reg      <= '0;
      rd_wait_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            address_reg    <= {byte_addr[31:6], 6'b0};
            writedata_reg  <= writedata_next;
            byteenable_reg <= byteenable_next;
            cycle_reg      <= '0;
`ifdef WRITE_LATENCY_VERIFY_EN
            lane_reg       <= lane_next;
            value_reg      <= m_input_value;
`endif
          end
        end
        WREQ, WACK: begin
          // The ack cycle itself is not counted.
          if (dst_writeack) begin
`ifdef WRITE_LATENCY_VERIFY_EN
            rd_wait_reg <= '0;
`else
            result_reg  <= cycle_reg;
`endif
          end else if (timeout_hit) begin
            result_reg <= 32'hFFFF_FFFF;
          end else begin
            cycle_reg <= cycle_inc;
          end
        end
`ifdef WRITE_LATENCY_VERIFY_EN
        RREQ, RDAT: begin
          if (state_reg == RDAT && dst_readdatavalid)
            result_reg <= rd_match ? cycle_reg : 32'd0;
          else if (rd_timeout)
            result_reg <= 32'hFFFF_FFFF;
          else
            rd_wait_reg <= (rd_wait_reg == 32'hFFFF_FFFF) ? rd_wait_reg : rd_wait_reg + 32'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign m_ready_out    = (state_reg == IDLE);
  assign m_valid_out    = (state_reg == DONE);
  assign m_output_value = result_reg;
  assign dst_write      = (state_reg == WREQ);
  assign dst_address    = address_reg;
  assign dst_writedata  = writedata_reg;
  assign dst_byteenable = byteenable_reg;
  assign dst_burstcount = 5'd1;

endmodule
